// File: rtl/piece_drop_ctrl.sv
`default_nettype none
// ============================================================================
// piece_drop_ctrl - keyboard-driven Connect Four piece sequencer with column
// fill tracking. Build option DROP_ANIM_EN animates the fall frame by frame.
// Revision: 1.0
// ============================================================================
module piece_drop_ctrl #(
  parameter int         COL_X0    = 180,
  parameter int         COL_PITCH = 40,
  parameter int         HOVER_Y   = 75,
  parameter int         ROW_Y0    = 115,
  parameter int         ROW_PITCH = 40,
  parameter int         DROP_STEP = 8,
  parameter logic [7:0] KEY_LEFT  = 8'h50,
  parameter logic [7:0] KEY_RIGHT = 8'h4F,
  parameter logic [7:0] KEY_DROP  = 8'h28
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       new_game,
  input  logic       game_over,
  output logic [9:0] PieceX,
  output logic [9:0] PieceY,
  output logic       player,
  output logic       place_valid,
  output logic [2:0] place_col,
  output logic [2:0] place_row,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FALL = 2'd1,
    ST_LAND = 2'd2
  } state_t;

  localparam logic [2:0] c_COL_MAX    = 3'd6;
  localparam logic [2:0] c_COL_RESET  = 3'd3;
  localparam logic [2:0] c_H_FULL     = 3'd6;
  localparam logic [2:0] c_ROW_BOTTOM = 3'd5;
  localparam logic [9:0] c_COL_X0     = 10'(COL_X0);
  localparam logic [9:0] c_COL_PITCH  = 10'(COL_PITCH);
  localparam logic [9:0] c_HOVER_Y    = 10'(HOVER_Y);
  localparam logic [9:0] c_ROW_Y0     = 10'(ROW_Y0);
  localparam logic [9:0] c_ROW_PITCH  = 10'(ROW_PITCH);
  localparam logic [9:0] c_DROP_STEP  = 10'(DROP_STEP);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_col;
  logic [9:0] r_y;
  logic       r_player;
  logic [2:0] r_height [0:6];
  logic [7:0] r_key_prev;
  logic [2:0] r_target_row;

  logic       w_key_new;
  logic       w_press_left;
  logic       w_press_right;
  logic       w_press_drop;
  logic [2:0] w_col_height;
  logic       w_col_full;
  logic [2:0] w_drop_row;
  logic [9:0] w_drop_y;
  logic [9:0] w_land_y;
  logic [9:0] w_step_y;
  logic       w_fall_done;
  logic       w_move_left;
  logic       w_move_right;
  logic       w_drop;

  // A key fires only on the frame its code first appears, so holds count once
  assign w_key_new     = (keycode != r_key_prev);
  assign w_press_left  = w_key_new && (keycode == KEY_LEFT);
  assign w_press_right = w_key_new && (keycode == KEY_RIGHT);
  assign w_press_drop  = w_key_new && (keycode == KEY_DROP);

  assign w_col_height = r_height[r_col];
  assign w_col_full   = (w_col_height >= c_H_FULL);
  assign w_drop_row   = c_ROW_BOTTOM - w_col_height;
  assign w_drop_y     = c_ROW_Y0 + 10'(w_drop_row) * c_ROW_PITCH;
  assign w_land_y     = c_ROW_Y0 + 10'(r_target_row) * c_ROW_PITCH;
  assign w_step_y     = r_y + c_DROP_STEP;
  assign w_fall_done  = (w_step_y >= w_land_y);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_move_left  = 1'b0;
    w_move_right = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press_left) begin
          w_move_left = (r_col != 3'd0);
        end else if (w_press_right) begin
          w_move_right = (r_col != c_COL_MAX);
        end else if (w_press_drop && !game_over && !w_col_full) begin
          w_drop = 1'b1;
`ifdef DROP_ANIM_EN
          w_state_nxt = ST_FALL;
`else
          w_state_nxt = ST_LAND;
`endif
        end
      end
      ST_FALL: begin
        if (w_fall_done) begin
          w_state_nxt = ST_LAND;
        end
      end
      ST_LAND: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // new_game wins over everything, including an in-flight drop
    if (new_game) begin
      w_state_nxt  = ST_IDLE;
      w_move_left  = 1'b0;
      w_move_right = 1'b0;
      w_drop       = 1'b0;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_col        <= c_COL_RESET;
      r_y          <= c_HOVER_Y;
      r_player     <= 1'b0;
      r_key_prev   <= 8'd0;
      r_target_row <= 3'd0;
      for (int i = 0; i < 7; i++) begin
        r_height[i] <= 3'd0;
      end
    end else begin
      r_key_prev <= keycode;
      if (new_game) begin
        r_col    <= c_COL_RESET;
        r_y      <= c_HOVER_Y;
        r_player <= 1'b0;
        for (int i = 0; i < 7; i++) begin
          r_height[i] <= 3'd0;
        end
      end else begin
        if (w_move_left) begin
          r_col <= r_col - 3'd1;
        end
        if (w_move_right) begin
          r_col <= r_col + 3'd1;
        end
        if (w_drop) begin
          r_target_row <= w_drop_row;
`ifndef DROP_ANIM_EN
          r_y <= w_drop_y;
`endif
        end
        // Last step clamps onto the landing row instead of overshooting it
        if (r_state == ST_FALL) begin
          r_y <= w_fall_done ? w_land_y : w_step_y;
        end
        if (r_state == ST_LAND) begin
          r_height[r_col] <= r_height[r_col] + 3'd1;
          r_y             <= c_HOVER_Y;
          r_player        <= ~r_player;
        end
      end
    end
  end

  assign PieceX      = c_COL_X0 + 10'(r_col) * c_COL_PITCH;
  assign PieceY      = r_y;
  assign player      = r_player;
  assign place_valid = (r_state == ST_LAND);
  assign place_col   = place_valid ? r_col : 3'd0;
  assign place_row   = place_valid ? r_target_row : 3'd0;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
